// File: rtl/ins_mem_boot_loader_if.sv
// ============================================================================
// Module      : ins_mem_boot_loader_if
// Description : Byte-stream boot handshake (valid/ready) feeding the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ins_mem_boot_loader_if;
    logic       BYTE_VALID;
    logic [7:0] BYTE_DATA;
    logic       BYTE_READY;

    modport master (
        output BYTE_VALID,
        output BYTE_DATA,
        input  BYTE_READY
    );

    modport slave (
        input  BYTE_VALID,
        input  BYTE_DATA,
        output BYTE_READY
    );
endinterface

`default_nettype wire

// File: rtl/ins_mem_boot_loader.sv
// ============================================================================
// Module      : ins_mem_boot_loader
// Description : Loads a length-prefixed big-endian word image into instruction
//               memory, then releases the CPU. Option macro: BOOT_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_mem_boot_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  wire logic                  CLK,
    input  wire logic                  RST,
    ins_mem_boot_loader_if.slave       boot_if,
    input  wire logic [ADDR_WIDTH-1:0] PC_to_ins_mem,
    output logic      [DATA_WIDTH-1:0] ins_mem_RD,
    output logic                       CPU_RST_N,
    output logic                       LOAD_DONE,
    output logic                       LOAD_ERR
);

    localparam int c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int c_CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM   = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t c_LOAD_END = S_CSUM;
`else
    localparam state_t c_LOAD_END = S_DONE;
`endif

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [15:0]           r_len;
    logic [15:0]           r_word_cnt;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_partial;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif
    logic                  r_cpu_rst_n;
    logic                  r_load_done;
    logic                  r_load_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic [15:0]           w_len_new;
    logic [c_CMP_W-1:0]    w_rd_idx;

    assign w_len_new   = {r_len[15:8], boot_if.BYTE_DATA};
    assign w_accept    = boot_if.BYTE_VALID && w_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_word = ((r_word_cnt + 16'd1) == r_len);

    always_comb begin
        w_ready = 1'b0;
        if (!RST) begin
            case (r_state)
                S_LEN_HI, S_LEN_LO, S_DATA: w_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                S_CSUM:                     w_ready = 1'b1;
`endif
                default:                    w_ready = 1'b0;
            endcase
        end
    end

    assign boot_if.BYTE_READY = w_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN_HI: if (w_accept) w_state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len_new == 16'd0)
                        w_state_next = c_LOAD_END;
                    else if ({16'd0, w_len_new} > 32'(MEM_DEPTH))
                        w_state_next = S_ERR;
                    else
                        w_state_next = S_DATA;
                end
            end
            S_DATA: if (w_accept && w_last_byte && w_last_word) w_state_next = c_LOAD_END;
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (w_accept)
                    w_state_next = (boot_if.BYTE_DATA == r_csum) ? S_DONE : S_ERR;
            end
`endif
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_LEN_HI;
        else     r_state <= w_state_next;
    end

    // Status flags are registered on the edge that enters the terminal state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_len       <= 16'd0;
            r_word_cnt  <= 16'd0;
            r_byte_cnt  <= 2'd0;
            r_partial   <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
            r_cpu_rst_n <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                case (r_state)
                    S_LEN_HI: r_len[15:8] <= boot_if.BYTE_DATA;
                    S_LEN_LO: r_len[7:0]  <= boot_if.BYTE_DATA;
                    S_DATA: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        r_csum     <= r_csum + boot_if.BYTE_DATA;
`endif
                        case (r_byte_cnt)
                            2'd0:    r_partial[23:16] <= boot_if.BYTE_DATA;
                            2'd1:    r_partial[15:8]  <= boot_if.BYTE_DATA;
                            2'd2:    r_partial[7:0]   <= boot_if.BYTE_DATA;
                            default: r_word_cnt       <= r_word_cnt + 16'd1;
                        endcase
                    end
                    default: ;
                endcase
            end
            if (w_state_next == S_DONE) begin
                r_cpu_rst_n <= 1'b1;
                r_load_done <= 1'b1;
            end
            if (w_state_next == S_ERR)
                r_load_err <= 1'b1;
        end
    end

    // Memory contents survive reset; the read gating hides stale words.
    always_ff @(posedge CLK) begin
        if (w_accept && (r_state == S_DATA) && w_last_byte)
            r_mem[c_IDX_W'(r_word_cnt)] <= DATA_WIDTH'({r_partial, boot_if.BYTE_DATA});
    end

    assign w_rd_idx = c_CMP_W'(PC_to_ins_mem >> 2);

    always_comb begin
        ins_mem_RD = '0;
        if (!RST && (r_state == S_DONE) &&
            (w_rd_idx < c_CMP_W'(r_len)) && (w_rd_idx < c_CMP_W'(MEM_DEPTH)))
            ins_mem_RD = r_mem[c_IDX_W'(w_rd_idx)];
    end

    assign CPU_RST_N = r_cpu_rst_n;
    assign LOAD_DONE = r_load_done;
    assign LOAD_ERR  = r_load_err;

endmodule

`default_nettype wire

// File: doc/ins_mem_boot_loader.md
INS_MEM_BOOT_LOADER -- requirements
Module: ins_mem_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of instruction address from processor.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, instruction words stored.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous reset, active-high.
REQ-006 SHALL have port BYTE_VALID  input  1  boot stream byte present.
REQ-007 SHALL have port BYTE_DATA  input  8  boot stream byte.
REQ-008 SHALL have port BYTE_READY  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port PC_to_ins_mem  input  ADDR_WIDTH  processor fetch address.
REQ-010 SHALL have port ins_mem_RD  output  DATA_WIDTH  instruction word to processor.
REQ-011 SHALL have port CPU_RST_N  output  1  active-low hold-reset to processor RST_N.
REQ-012 SHALL have port LOAD_DONE  output  1  image loaded successfully.
REQ-013 SHALL have port LOAD_ERR  output  1  image rejected.

Function
REQ-014 SHALL accept a byte on a rising edge where BYTE_VALID and BYTE_READY are both 1; no other byte is consumed.
REQ-015 SHALL implement states LEN_HI, LEN_LO, DATA, (CSUM), DONE, ERR; BYTE_READY = 1 only in LEN_HI/LEN_LO/DATA/CSUM with RST low.
REQ-016 SHALL take word count N as 16 bits: LEN_HI byte = N[15:8], LEN_LO byte = N[7:0].
REQ-017 SHALL, on accepting LEN_LO: N = 0 -> DONE; N > MEM_DEPTH -> ERR; else -> DATA.
REQ-018 SHALL assemble each word big-endian from 4 accepted bytes (first byte = bits 31:24) and write it to word index 0,1,...,N-1 on the edge accepting the 4th byte.
REQ-019 SHALL make a written word visible on ins_mem_RD from the cycle after its write edge.
REQ-020 SHALL, after the Nth word is written, go to DONE (or CSUM when configured).
REQ-021 SHALL drive ins_mem_RD combinationally as mem[PC_to_ins_mem >> 2]; PC_to_ins_mem[1:0] ignored.
REQ-022 SHALL drive ins_mem_RD = 0 when not in DONE, or when word index >= N, or index >= MEM_DEPTH.
REQ-023 SHALL register CPU_RST_N = 1 and LOAD_DONE = 1 on the edge entering DONE; both stay until RST.
REQ-024 SHALL register LOAD_ERR = 1 on the edge entering ERR; CPU_RST_N stays 0; ERR exits only via RST.
REQ-025 SHALL ignore BYTE_VALID in DONE and ERR; no memory write outside DATA.
REQ-026 SHALL hold partial-word state indefinitely when BYTE_VALID is 0 (no timeout).

Reset
REQ-027 SHALL, with RST high at an edge, enter LEN_HI, clear byte/word counters, stored N, partial word and checksum.
REQ-028 SHALL reset CPU_RST_N = 0, LOAD_DONE = 0, LOAD_ERR = 0; BYTE_READY = 0 and ins_mem_RD = 0 while RST is high.
REQ-029 SHALL discard a partially received image on RST mid-load; memory array contents are not cleared but are unreadable until a new load completes.

Configuration
REQ-030 SHALL, with BOOT_CHECKSUM_EN defined, expect one extra byte after the Nth word in state CSUM equal to the 8-bit sum (mod 256) of all 4N data bytes; match -> DONE, mismatch -> ERR; N = 0 also passes through CSUM with expected value 0x00.
REQ-031 SHALL, without BOOT_CHECKSUM_EN, omit CSUM and the checksum register; last word goes directly to DONE.

Verification
REQ-032 SHALL cover: bytes 00 02 20 08 00 05 8C 01 00 04, VALID every cycle -> LOAD_DONE=1, CPU_RST_N=1; PC=0 -> 0x20080005, PC=4 -> 0x8C010004, PC=8 -> 0.
REQ-033 SHALL cover: length 01 01 (N=257, MEM_DEPTH=256) -> LOAD_ERR=1, BYTE_READY=0, CPU_RST_N=0, no write.
REQ-034 SHALL cover: N=1 with BYTE_VALID toggling 1/0 each cycle -> exactly 6 bytes accepted, word written on 6th acceptance edge, extra bytes ignored in DONE.
REQ-035 SHALL cover: RST pulse after 3 bytes of word 0, then full load N=1 word 0xDEADBEEF -> ins_mem_RD(PC=0)=0xDEADBEEF; PC=3 also returns it.
REQ-036 SHALL cover (BOOT_CHECKSUM_EN): N=1 word 0x01020304 then checksum 0x0A -> DONE; checksum 0x0B -> LOAD_ERR=1.
REQ-037 SHALL cover: length 00 00 -> DONE on edge accepting 2nd byte (no BOOT_CHECKSUM_EN), ins_mem_RD=0 for all PC.
